// File: rtl/cordic_arbiter.sv
// cordic_arbiter: round-robin front end that time-shares one cordic_top core
// among NUM_REQ requesters. One operation is in flight at a time. An operation
// that never sees core_done is aborted after TIMEOUT wait cycles, and the core
// is then recovered with a one-cycle core_rst pulse.
module cordic_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2,
    parameter int TIMEOUT = 255
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [32*NUM_REQ-1:0]  req_angle,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic [NUM_REQ-1:0]     resp_valid,
    output logic [31:0]            resp_sin,
    output logic [31:0]            resp_cos,
    output logic                   resp_timeout,
    output logic [IDX_W-1:0]       resp_idx,
    output logic                   busy,
    output logic                   core_rst,
    output logic                   core_valid,
    output logic [31:0]            core_angle,
    input  logic [31:0]            core_sin,
    input  logic [31:0]            core_cos,
    input  logic                   core_done
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] grant;
    logic [IDX_W-1:0] last_grant;
    logic [CNT_W-1:0] wait_cnt;
    logic             timeout_flag;

    logic             pick_valid;
    logic [IDX_W-1:0] pick_idx;
    logic [IDX_W-1:0] cand;
    logic [31:0]      angle_arr [NUM_REQ];

    // Unpack the flat angle bus so the winner can be selected by index.
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_angle
        assign angle_arr[g] = req_angle[32*g +: 32];
    end

    // Round-robin pick: first requester above last_grant, wrapping modulo NUM_REQ.
    // NOTE: every variable gets a default before the loop, so no path leaves
    // a value unassigned and no latch is inferred.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        // Walk from the farthest candidate to the nearest so the nearest wins.
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand = IDX_W'((int'(last_grant) + k) % NUM_REQ);
            if (req_valid[cand]) begin
                pick_valid = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    // Core reset follows the system reset and also pulses on an aborted operation.
    assign core_rst = rst | ((state == RESP) & timeout_flag);

    // Control FSM with all outputs registered.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register sees the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            grant        <= '0;
            last_grant   <= IDX_W'(NUM_REQ - 1);
            wait_cnt     <= '0;
            timeout_flag <= 1'b0;
            req_ready    <= '0;
            resp_valid   <= '0;
            resp_sin     <= '0;
            resp_cos     <= '0;
            resp_timeout <= 1'b0;
            resp_idx     <= '0;
            busy         <= 1'b0;
            core_valid   <= 1'b0;
            core_angle   <= '0;
        end else begin
            // Pulse outputs drop by default and are raised only in their one cycle.
            req_ready    <= '0;
            resp_valid   <= '0;
            resp_timeout <= 1'b0;
            core_valid   <= 1'b0;

            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        grant      <= pick_idx;
                        core_angle <= angle_arr[pick_idx];
                        req_ready  <= NUM_REQ'(1) << pick_idx;
                        core_valid <= 1'b1;
                        busy       <= 1'b1;
                        state      <= ISSUE;
                    end
                end

                ISSUE: begin
                    wait_cnt <= '0;
                    state    <= WAIT;
                end

                WAIT: begin
                    wait_cnt <= wait_cnt + CNT_W'(1);
                    // A done on the final wait cycle takes priority over the abort.
                    if (core_done) begin
                        resp_sin     <= core_sin;
                        resp_cos     <= core_cos;
                        timeout_flag <= 1'b0;
                        resp_valid   <= NUM_REQ'(1) << grant;
                        resp_idx     <= grant;
                        state        <= RESP;
                    end else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
                        resp_sin     <= '0;
                        resp_cos     <= '0;
                        timeout_flag <= 1'b1;
                        resp_valid   <= NUM_REQ'(1) << grant;
                        resp_timeout <= 1'b1;
                        resp_idx     <= grant;
                        state        <= RESP;
                    end
                end

                RESP: begin
                    last_grant <= grant;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end

                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cordic_arbiter.sv
// Self-checking bench for cordic_arbiter. A behavioural core model answers each
// core_valid after a chosen latency (or never). A round-robin reference model
// predicts grant order, timing and response contents.
module tb_cordic_arbiter;

    localparam int NUM_REQ = 4;
    localparam int IDX_W   = 2;
    localparam int TIMEOUT = 48;
    localparam int BOUND   = 20;

    logic                  clk;
    logic                  rst;
    logic [NUM_REQ-1:0]    req_valid;
    wire  [32*NUM_REQ-1:0] req_angle;
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ-1:0]    resp_valid;
    logic [31:0]           resp_sin;
    logic [31:0]           resp_cos;
    logic                  resp_timeout;
    logic [IDX_W-1:0]      resp_idx;
    logic                  busy;
    logic                  core_rst;
    logic                  core_valid;
    logic [31:0]           core_angle;
    logic [31:0]           core_sin;
    logic [31:0]           core_cos;
    logic                  core_done;

    logic [31:0] drv_ang [NUM_REQ];
    int          vectors = 0;
    int          errors  = 0;
    int          lat     = 0;
    bit          spur_done = 1'b0;
    int          model_last;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_drv
        assign req_angle[32*g +: 32] = drv_ang[g];
    end

    cordic_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_angle    (req_angle),
        .req_ready    (req_ready),
        .resp_valid   (resp_valid),
        .resp_sin     (resp_sin),
        .resp_cos     (resp_cos),
        .resp_timeout (resp_timeout),
        .resp_idx     (resp_idx),
        .busy         (busy),
        .core_rst     (core_rst),
        .core_valid   (core_valid),
        .core_angle   (core_angle),
        .core_sin     (core_sin),
        .core_cos     (core_cos),
        .core_done    (core_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Result words the core model produces for a given angle.
    function automatic logic [63:0] core_fn(input logic [31:0] a);
        if (a == 32'h3F80_0000) return {32'h3F57_6AA4, 32'h3F0A_5140};
        return {a ^ 32'hA5A5_0F0F, {a[15:0], a[31:16]} ^ 32'h1357_9BDF};
    endfunction

    function automatic logic [NUM_REQ-1:0] onehot(input int i);
        logic [NUM_REQ-1:0] v;
        v = '0;
        v[i[IDX_W-1:0]] = 1'b1;
        return v;
    endfunction

    // Core model: done arrives lat cycles after the cycle core_valid was high;
    // lat == 0 means the core never answers. core_rst cancels a pending answer.
    logic        m_v, m_r;
    logic [31:0] m_angle;
    logic [63:0] m_res;
    int          m_cnt = 0;
    bit          m_pend = 1'b0;
    initial begin
        core_done = 1'b0;
        core_sin  = '0;
        core_cos  = '0;
    end
    always @(posedge clk) begin
        m_v     = core_valid;
        m_r     = core_rst;
        m_angle = core_angle;
        #1;
        core_done = spur_done;
        core_sin  = $urandom;
        core_cos  = $urandom;
        if (m_r) begin
            m_pend = 1'b0;
        end else begin
            if (m_v) begin
                m_pend = (lat > 0);
                m_cnt  = lat;
                m_res  = core_fn(m_angle);
            end
            if (m_pend) begin
                m_cnt--;
                if (m_cnt == 0) begin
                    core_done = 1'b1;
                    core_sin  = m_res[63:32];
                    core_cos  = m_res[31:0];
                    m_pend    = 1'b0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Raise req_valid on every requester in mask and serve them all, checking
    // each grant against the round-robin model. lat_fix < 0 picks random latencies.
    task automatic serve(input logic [NUM_REQ-1:0] mask, input int lat_fix, input bit use_fixed);
        logic [NUM_REQ-1:0] pending;
        logic [31:0]        ang [NUM_REQ];
        logic [63:0]        r;
        int                 w, c, n, l, d, bad;
        bit                 to;
        pending = mask;
        for (int i = 0; i < NUM_REQ; i++) begin
            ang[i] = use_fixed ? 32'h3F80_0000 : $urandom;
            if (mask[i]) drv_ang[i] = ang[i];
        end
        req_valid = mask;
        while (pending != '0) begin
            w = -1;
            for (int k = 1; k <= NUM_REQ; k++) begin
                c = (model_last + k) % NUM_REQ;
                if (w < 0 && pending[c[IDX_W-1:0]]) w = c;
            end
            n = 0;
            while (req_ready === '0 && n < BOUND) begin
                tick();
                n++;
            end
            check("grant_latency", 64'(n), 64'd1);
            check("req_ready", 64'(req_ready), 64'(onehot(w)));
            check("core_valid", 64'(core_valid), 64'd1);
            check("core_angle", 64'(core_angle), 64'(ang[w[IDX_W-1:0]]));
            check("busy_issue", 64'(busy), 64'd1);
            if (lat_fix >= 0) l = lat_fix;
            else l = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 30));
            lat = l;
            to  = (l == 0);
            d   = to ? TIMEOUT + 1 : l + 1;
            req_valid[w[IDX_W-1:0]] = 1'b0;
            drv_ang[w[IDX_W-1:0]]   = $urandom;
            pending[w[IDX_W-1:0]]   = 1'b0;
            bad = 0;
            for (int t = 1; t < d; t++) begin
                tick();
                if (resp_valid !== '0 || busy !== 1'b1 || core_rst !== 1'b0 ||
                    req_ready !== '0 || core_valid !== 1'b0) bad++;
            end
            check("wait_quiet", 64'(bad), 64'd0);
            tick();
            r = to ? 64'd0 : core_fn(ang[w[IDX_W-1:0]]);
            check("resp_valid", 64'(resp_valid), 64'(onehot(w)));
            check("resp_idx", 64'(resp_idx), 64'(w));
            check("resp_timeout", 64'(resp_timeout), 64'(to));
            check("resp_sin", 64'(resp_sin), 64'(r[63:32]));
            check("resp_cos", 64'(resp_cos), 64'(r[31:0]));
            check("core_rst_resp", 64'(core_rst), 64'(to));
            tick();
            check("resp_pulse_end", 64'(resp_valid), 64'd0);
            check("busy_idle", 64'(busy), 64'd0);
            check("core_rst_end", 64'(core_rst), 64'd0);
            model_last = w;
        end
    endtask

    initial begin
        int bad;
        rst       = 1'b1;
        req_valid = '0;
        for (int i = 0; i < NUM_REQ; i++) drv_ang[i] = '0;
        model_last = NUM_REQ - 1;
        tick();
        tick();
        check("rst_core_rst", 64'(core_rst), 64'd1);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_outputs", 64'({req_ready, resp_valid, core_valid, resp_timeout}), 64'd0);
        rst = 1'b0;
        tick();
        check("idle_core_rst", 64'(core_rst), 64'd0);

        // Contention from reset: expect grants 0,1,2,3.
        serve(4'b1111, -1, 1'b0);

        // Single request on requester 1 with the reference angle, L=40.
        serve(4'b0010, 40, 1'b1);

        // Round-robin wrap: leave last_grant at 2, then 0 and 3 together.
        serve(4'b0100, 5, 1'b0);
        serve(4'b1001, 7, 1'b0);

        // Timeout, then a normal operation.
        serve(4'b0001, 0, 1'b0);
        serve(4'b0100, 12, 1'b0);

        // Done on the final wait cycle resolves as done.
        serve(4'b1000, TIMEOUT, 1'b0);

        // Reset in WAIT discards the operation.
        lat = 0;
        drv_ang[0]   = 32'h4000_0000;
        req_valid    = 4'b0001;
        tick();
        check("mid_ready", 64'(req_ready), 64'd1);
        req_valid = '0;
        for (int i = 0; i < 5; i++) tick();
        check("mid_busy", 64'(busy), 64'd1);
        rst = 1'b1;
        #1;
        check("mid_core_rst_now", 64'(core_rst), 64'd1);
        tick();
        check("mid_rst_ctrl", 64'({req_ready, resp_valid, core_valid, resp_timeout, busy}), 64'd0);
        check("mid_rst_data", {resp_sin, resp_cos}, 64'd0);
        check("mid_rst_misc", 64'({core_angle, resp_idx}), 64'd0);
        check("mid_core_rst", 64'(core_rst), 64'd1);
        tick();
        rst = 1'b0;
        model_last = NUM_REQ - 1;
        bad = 0;
        spur_done = 1'b1;
        tick();
        spur_done = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (resp_valid !== '0 || busy !== 1'b0 || core_valid !== 1'b0) bad++;
        end
        check("spurious_done", 64'(bad), 64'd0);

        // After reset requester 0 wins first again.
        serve(4'b1111, -1, 1'b0);

        // Randomized request patterns.
        for (int it = 0; it < 8; it++) begin
            serve(NUM_REQ'($urandom_range(1, (1 << NUM_REQ) - 1)), -1, 1'b0);
            for (int j = 0; j < int'($urandom_range(0, 3)); j++) tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/cordic_arbiter.md
# cordic_arbiter

Shares a single `cordic_top` instance among `NUM_REQ` independent requesters. Each request is one float angle, and each response is a float sin/cos pair. The arbiter grants requesters round-robin, issues one operation to the core at a time, and waits for the core's `done`. It then returns the result to the granted requester and recovers the core with a reset pulse if `done` never arrives. It sits between the system-side clients and `cordic_top`, and drives every core input.

## Interface
Parameters:
- `NUM_REQ`, 4, number of requesters (2..8).
- `IDX_W`, 2, grant index width, `$clog2(NUM_REQ)`.
- `TIMEOUT`, 255, maximum WAIT cycles before abort (≥2).

Ports:
- `clk`  in  1  single clock, all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  NUM_REQ  per-requester request; held until `req_ready`.
- `req_angle`  in  32*NUM_REQ  packed float angles; requester i at bits [32i+31:32i].
- `req_ready`  out  NUM_REQ  one-hot, one-cycle accept pulse.
- `resp_valid`  out  NUM_REQ  one-hot, one-cycle response pulse.
- `resp_sin`, `resp_cos`  out  32 each  result floats; valid only with `resp_valid`.
- `resp_timeout`  out  1  qualifies `resp_valid`: the operation was aborted.
- `resp_idx`  out  IDX_W  index of the responding requester.
- `busy`  out  1  high in every state except IDLE.
- `core_rst`  out  1  to `cordic_top.rst`.
- `core_valid`  out  1  to `cordic_top.valid_in`; one-cycle pulse.
- `core_angle`  out  32  to `cordic_top.angle_float`.
- `core_sin`, `core_cos`  in  32 each  from `cordic_top`.
- `core_done`  in  1  from `cordic_top.done`.

## Operation
- FSM states are IDLE, ISSUE, WAIT and RESP.
- **IDLE**
  - If any `req_valid` is set, select the first set bit searching upward from `last_grant+1`, modulo NUM_REQ.
  - Latch the winner's index into `grant` and its angle into `core_angle`, then go to ISSUE.
  - If no `req_valid` is set, stay in IDLE.
- **ISSUE** (one cycle)
  - Assert `core_valid=1` and `req_ready[grant]=1`.
  - Clear the WAIT counter and go to WAIT.
- **WAIT**
  - Increment the counter each cycle.
  - On `core_done=1`: latch `core_sin`/`core_cos` into `resp_sin`/`resp_cos`, clear the timeout flag, and go to RESP.
  - If the counter reaches TIMEOUT with no `core_done`: set `resp_sin=resp_cos=0`, set the timeout flag, and go to RESP.
  - `core_done` and the timeout arriving in the same cycle resolve as done (the result is kept).
- **RESP** (one cycle)
  - Assert `resp_valid[grant]=1` and `resp_idx=grant`, with `resp_timeout` taken from the flag.
  - Set `last_grant<=grant` and return to IDLE.
  - On a timeout, `core_rst` pulses high in this same cycle.
- `core_rst = rst | (state==RESP & timeout flag)`.
- `core_done` seen in IDLE, ISSUE or RESP is ignored. A stale done cannot reach a later operation because every abort resets the core.
- Responses have no backpressure: requesters must accept `resp_valid` unconditionally.
- `req_angle` is sampled only in the IDLE grant cycle. Changing it afterwards has no effect.
- Dropping `req_valid` before `req_ready` is a protocol violation. The arbiter still issues the already-granted operation.
- **Reset**
  - State goes to IDLE and `last_grant` to NUM_REQ-1, so requester 0 wins first after reset.
  - All registered outputs go to 0: `req_ready`, `resp_valid`, `resp_sin`, `resp_cos`, `resp_timeout`, `resp_idx`, `busy`, `core_valid`, `core_angle`.
  - `core_rst` is high throughout reset.
  - Reset asserted mid-operation discards the pending operation without producing a response. The core is reset at the same time through `core_rst`.

## Timing
- Request visible at cycle 0 in IDLE:
  - `req_ready` and `core_valid` assert at cycle 1.
  - If the core raises `done` at cycle 1+L, `resp_valid` asserts at cycle 2+L.
  - The FSM is back in IDLE at cycle 3+L.
- The next grant decision is made in that IDLE cycle. Sustained throughput is one operation per L+3 cycles.
- On timeout, `resp_valid`/`resp_timeout`/`core_rst` assert at cycle 2+TIMEOUT.
- `req_ready`, `resp_valid`, `core_valid` and `core_rst` (excluding reset) are single-cycle pulses. Each is asserted at most once per operation.
- Fairness: while requester i keeps `req_valid` high, at most NUM_REQ-1 other operations complete before it is granted.

## Test plan
- **Single request:** `req_valid[1]=1` with `req_angle[1]=0x3F800000`; the core model returns sin=0x3F576AA4, cos=0x3F0A5140 with L=40.
  - Required: `req_ready[1]` pulses at cycle 1.
  - Required: `resp_valid[1]` at cycle 42 with those exact words, `resp_idx=1`, `resp_timeout=0`.
- **Contention:** all four `req_valid` set high from reset and each held until its `req_ready`.
  - Required: grants in order 0,1,2,3, each response carrying its own angle's model result.
- **Round-robin wrap:** `last_grant=2`, then requesters 0 and 3 request together.
  - Required: grant 3 first, then 0.
- **Timeout:** the core model never raises done, with TIMEOUT=8.
  - Required: at cycle 10, `resp_valid` and `resp_timeout` are 1, sin=cos=0, and `core_rst` pulses for exactly one cycle.
  - Required: the next request completes normally.
- **Done on the timeout cycle:** `core_done` arrives exactly on the TIMEOUT-th WAIT cycle.
  - Required: `resp_timeout=0`, the data is latched, and there is no `core_rst` pulse.
- **Reset mid-WAIT / spurious done:** assert `rst` in WAIT.
  - Required: no `resp_valid`, all outputs read 0, `core_rst` is high.
  - After reset, pulse `core_done` in IDLE. Required: no response.
